// File: rtl/pipe_stage_skid.sv
// Ready/valid pipeline stage with a 2-entry skid buffer, so in_ready comes straight from a flop.
// A flush inserts bubbles. Saturating stall and bubble counters feed the performance monitor.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W     = 24,
  parameter int unsigned DATA_W     = 128,
  parameter bit          CLEAR_DATA = 1'b0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic in_fire;

  assign in_ready  = ~skid_valid_q;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        // Unreachable while in_ready is tied to !skid_valid; kept so ordering stays FIFO.
        if (in_fire) begin
          skid_valid_d = 1'b1;
          skid_ctrl_d  = in_ctrl;
          skid_data_d  = in_data;
        end
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else begin
        // Bubble: control cleared so downstream can decode enables without gating on valid.
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (!main_valid_q && (bubble_cnt_q != CntMax)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic, all checked against a
// queue-based reference model. A second instance with CLEAR_DATA=1 shares the stimulus.
module tb_pipe_stage_skid;

  localparam int unsigned CtrlW = 8;
  localparam int unsigned DataW = 16;
  localparam int unsigned CntW  = 4;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, out_ready;
  logic [CtrlW-1:0] in_ctrl;
  logic [DataW-1:0] in_data;

  logic             in_ready, out_valid;
  logic [CtrlW-1:0] out_ctrl;
  logic [DataW-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CntW-1:0]  stall_cnt, bubble_cnt;

  logic             in_ready_c, out_valid_c;
  logic [CtrlW-1:0] out_ctrl_c;
  logic [DataW-1:0] out_data_c;
  logic [1:0]       occupancy_c;
  logic [CntW-1:0]  stall_cnt_c, bubble_cnt_c;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the stage is a FIFO of at most two entries.
  logic [CtrlW-1:0] mq_ctrl[$];
  logic [DataW-1:0] mq_data[$];
  logic [DataW-1:0] m_last, m_last_clr;
  int unsigned      m_stall, m_bubble;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .CTRL_W(CtrlW), .DATA_W(DataW), .CLEAR_DATA(1'b0), .CNT_W(CntW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_skid #(
    .CTRL_W(CtrlW), .DATA_W(DataW), .CLEAR_DATA(1'b1), .CNT_W(CntW)
  ) dut_clr (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_c), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_ctrl(out_ctrl_c),
    .out_data(out_data_c), .occupancy(occupancy_c), .stall_cnt(stall_cnt_c),
    .bubble_cnt(bubble_cnt_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  sz;
    bit  in_fire, out_fire;
    sz       = mq_ctrl.size();
    in_fire  = in_valid && (sz < 2);
    out_fire = (sz > 0) && out_ready;
    if (reset) begin
      mq_ctrl.delete();
      mq_data.delete();
      m_last = '0;
      m_last_clr = '0;
      m_stall = 0;
      m_bubble = 0;
    end else begin
      if (sz > 0 && !out_ready && m_stall < CntMax) m_stall++;
      if (sz == 0 && m_bubble < CntMax) m_bubble++;
      if (flush) begin
        mq_ctrl.delete();
        mq_data.delete();
        m_last_clr = '0;
      end else begin
        if (out_fire) begin
          void'(mq_ctrl.pop_front());
          void'(mq_data.pop_front());
        end
        if (in_fire) begin
          mq_ctrl.push_back(in_ctrl);
          mq_data.push_back(in_data);
        end
        if (mq_ctrl.size() > 0) begin
          m_last = mq_data[0];
          m_last_clr = mq_data[0];
        end
      end
    end
  endtask

  task automatic check_all();
    bit v;
    v = mq_ctrl.size() > 0;
    check("in_ready", 32'(in_ready), 32'(mq_ctrl.size() < 2));
    check("out_valid", 32'(out_valid), 32'(v));
    check("out_ctrl", 32'(out_ctrl), v ? 32'(mq_ctrl[0]) : 32'd0);
    check("out_data", 32'(out_data), v ? 32'(mq_data[0]) : 32'(m_last));
    check("occupancy", 32'(occupancy), 32'(mq_ctrl.size()));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("bubble_cnt", 32'(bubble_cnt), 32'(m_bubble));
    check("clr_out_valid", 32'(out_valid_c), 32'(v));
    check("clr_out_ctrl", 32'(out_ctrl_c), v ? 32'(mq_ctrl[0]) : 32'd0);
    check("clr_out_data", 32'(out_data_c), v ? 32'(mq_data[0]) : 32'(m_last_clr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input logic [CtrlW-1:0] c, input bit rdy);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = DataW'($urandom);
    out_ready = rdy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    m_last = '0; m_last_clr = '0; m_stall = 0; m_bubble = 0;
    @(negedge clk);
    do_reset();

    // Streaming at full throughput.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CtrlW'(i), 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    tick();
    tick();

    // Backpressure: A in main, B in skid, C held upstream until released.
    do_reset();
    drive(1'b1, 8'h0A, 1'b0); tick();
    drive(1'b1, 8'h0B, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h0C, 1'b0); tick();
    end
    check("bp_occupancy", 32'(occupancy), 32'd2);
    drive(1'b1, 8'h0C, 1'b1); tick();
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) tick();

    // Flush with the skid full and a concurrent input.
    do_reset();
    drive(1'b1, 8'h01, 1'b0); tick();
    drive(1'b1, 8'h02, 1'b0); tick();
    flush = 1'b1;
    drive(1'b1, 8'h05, 1'b0); tick();
    flush = 1'b0;
    check("flush_occupancy", 32'(occupancy), 32'd0);
    check("flush_clr_data", 32'(out_data_c), 32'd0);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) tick();

    // Out_fire with both entries held, upstream still offering 0x3.
    drive(1'b1, 8'h01, 1'b0); tick();
    drive(1'b1, 8'h02, 1'b0); tick();
    drive(1'b1, 8'h03, 1'b1); tick();
    drive(1'b1, 8'h03, 1'b1); tick();
    drive(1'b0, '0, 1'b1); tick(); tick();

    // Reset wins over flush; data cleared even with CLEAR_DATA=0.
    in_valid = 1'b1; in_ctrl = 8'h11; in_data = 16'hDEAD; out_ready = 1'b0;
    tick();
    check("dead_loaded", 32'(out_data), 32'h0000DEAD);
    reset = 1'b1; flush = 1'b1; in_valid = 1'b0;
    tick();
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_bubble", 32'(bubble_cnt), 32'd0);
    reset = 1'b0; flush = 1'b0;

    // Saturation of the bubble counter.
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    check("bubble_sat", 32'(bubble_cnt), 32'(CntMax));

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), CtrlW'($urandom), ($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
